// File: rtl/fft16_pkg.sv
// fft16_pkg: shared sizes and controller state encoding for the 16-point FFT sequencer
package fft16_pkg;
    localparam int FFT_N = 16;
    localparam int FFT_LOG2N = 4;
    localparam int TW_DEPTH = 8;
    localparam int ADDR_W = 4;
    localparam int TW_W = 3;
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
endpackage

// File: rtl/fft16_bf_addr_gen.sv
// fft16_bf_addr_gen: maps (stage, butterfly k) to DIF operand addresses and twiddle index
module fft16_bf_addr_gen
    import fft16_pkg::*;
(
    input  logic [1:0]        stage,
    input  logic [2:0]        k,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [TW_W-1:0]   tw_idx
);
    logic [3:0] kx, span, mask;
    always_comb begin
        kx = {1'b0, k};
        span = 4'd8 >> stage;
        mask = span - 4'd1;
        addr_a = ((kx >> (2'd3 - stage)) << (3'd4 - {1'b0, stage})) | (kx & mask);
        addr_b = addr_a + span;
        tw_idx = 3'((kx & mask) << stage);
    end
endmodule

// File: rtl/fft16_stage_ctrl.sv
// fft16_stage_ctrl: walks 4 DIF stages x 8 butterflies, one butterfly per accepted cycle
module fft16_stage_ctrl
    import fft16_pkg::*;
#(
    parameter int STAGE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bf_ready,
    output logic              bf_valid,
    output logic [1:0]        stage,
    output logic [2:0]        bf_idx,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [TW_W-1:0]   tw_idx,
    output logic              last_bf,
    output logic              busy,
    output logic              done
);
    localparam int N_STAGES = 4;
    state_t state, state_nxt;
    logic [1:0] stage_nxt;
    logic [2:0] k_nxt, gap_cnt, gap_nxt;
    logic valid_nxt, busy_nxt, done_nxt, last_nxt;
    logic [ADDR_W-1:0] a_nxt, b_nxt;
    logic [TW_W-1:0] tw_nxt;

    // addresses are computed from the next-state counters so they register alongside them
    fft16_bf_addr_gen u_addr (
        .stage(stage_nxt),
        .k(k_nxt),
        .addr_a(a_nxt),
        .addr_b(b_nxt),
        .tw_idx(tw_nxt)
    );

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        k_nxt = bf_idx;
        gap_nxt = gap_cnt;
        valid_nxt = bf_valid;
        busy_nxt = busy;
        done_nxt = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = RUN;
                stage_nxt = 2'd0;
                k_nxt = 3'd0;
                valid_nxt = 1'b1;
                busy_nxt = 1'b1;
            end
            RUN: if (bf_ready) begin
                if (bf_idx != 3'd7) k_nxt = bf_idx + 3'd1;
                else if (stage == 2'(N_STAGES - 1)) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b0;
                    done_nxt = 1'b1;
                end else if (STAGE_GAP > 0) begin
                    state_nxt = GAP;
                    valid_nxt = 1'b0;
                    gap_nxt = 3'd0;
                end else begin
                    stage_nxt = stage + 2'd1;
                    k_nxt = 3'd0;
                end
            end
            GAP: if (gap_cnt == 3'(STAGE_GAP - 1)) begin
                state_nxt = RUN;
                stage_nxt = stage + 2'd1;
                k_nxt = 3'd0;
                valid_nxt = 1'b1;
            end else gap_nxt = gap_cnt + 3'd1;
            DONE: begin
                state_nxt = IDLE;
                busy_nxt = 1'b0;
            end
        endcase
        last_nxt = valid_nxt && stage_nxt == 2'd3 && k_nxt == 3'd7;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gap_cnt <= '0;
            bf_valid <= 1'b0;
            stage <= '0;
            bf_idx <= '0;
            addr_a <= '0;
            addr_b <= '0;
            tw_idx <= '0;
            last_bf <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_nxt;
            gap_cnt <= gap_nxt;
            bf_valid <= valid_nxt;
            stage <= stage_nxt;
            bf_idx <= k_nxt;
            addr_a <= a_nxt;
            addr_b <= b_nxt;
            tw_idx <= tw_nxt;
            last_bf <= last_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end
endmodule

// File: tb/tb_fft16_stage_ctrl.sv
// tb_fft16_stage_ctrl: random-backpressure bench against an arithmetic butterfly model
module tb_fft16_stage_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] ready = '0;
    logic [1:0] valid, last, busy, done;
    logic [1:0] stg [2];
    logic [2:0] kk [2];
    logic [3:0] aa [2];
    logic [3:0] bb [2];
    logic [2:0] tw [2];
    int total = 0;
    int bad = 0;
    int ma [32];
    int mb [32];
    int mt [32];
    logic ov, ol, obusy, odone;
    logic [1:0] ost;
    logic [2:0] ok_, otw;
    logic [3:0] oa, ob;

    always #5 clk = ~clk;

    fft16_stage_ctrl #(.STAGE_GAP(2)) dut_g2 (
        .clk(clk), .rst(rst), .start(start[0]), .bf_ready(ready[0]),
        .bf_valid(valid[0]), .stage(stg[0]), .bf_idx(kk[0]), .addr_a(aa[0]),
        .addr_b(bb[0]), .tw_idx(tw[0]), .last_bf(last[0]), .busy(busy[0]), .done(done[0])
    );

    fft16_stage_ctrl #(.STAGE_GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .start(start[1]), .bf_ready(ready[1]),
        .bf_valid(valid[1]), .stage(stg[1]), .bf_idx(kk[1]), .addr_a(aa[1]),
        .addr_b(bb[1]), .tw_idx(tw[1]), .last_bf(last[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int d);
        ov = valid[d]; ost = stg[d]; ok_ = kk[d]; oa = aa[d]; ob = bb[d];
        otw = tw[d]; ol = last[d]; obusy = busy[d]; odone = done[d];
    endtask

    // one transform on dut d; stall_idx forces 3 stall cycles on that butterfly, rst_idx aborts there
    task automatic run_tf(input int d, input int g, input int pct, input int stall_idx, input int rst_idx);
        int idx = 0, gaps = 0, stalls = 0, held = 0, n = 0, seen = -1;
        bit fin = 0, first;
        start[d] = 1'b1;
        ready[d] = ($urandom_range(99) < pct);
        cyc();
        start[d] = 1'b0;
        while (!fin && n < 600) begin
            n++;
            sample(d);
            if (rst_idx == idx && ov) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                sample(d);
                chk("rst_clear", {ov, ost, ok_, oa, ob, otw, ol, obusy, odone}, 0);
                cyc();
                sample(d);
                chk("rst_no_done", {ov, obusy, odone}, 0);
                fin = 1;
            end else if (odone) begin
                chk("done_idx", idx, 32);
                chk("done_busy", obusy, 1);
                chk("done_time", n, 33 + 3 * g + stalls);
                start[d] = 1'b1;
                cyc();
                start[d] = 1'b0;
                sample(d);
                chk("idle_after_done", {ov, obusy, odone}, 0);
                cyc();
                sample(d);
                chk("start_in_done_ignored", {ov, obusy, odone}, 0);
                fin = 1;
            end else begin
                chk("busy", obusy, 1);
                if (ov) begin
                    first = (seen != idx);
                    seen = idx;
                    chk("gap_len", gaps, (first && idx > 0 && idx % 8 == 0) ? g : 0);
                    gaps = 0;
                    chk("stage", ost, idx / 8);
                    chk("bf_idx", ok_, idx % 8);
                    chk("addr_a", oa, ma[idx]);
                    chk("addr_b", ob, mb[idx]);
                    chk("tw_idx", otw, mt[idx]);
                    chk("last_bf", ol, idx == 31);
                    start[d] = (idx == 10 && first);
                    if (idx == stall_idx && held < 3) begin
                        ready[d] = 1'b0;
                        held++;
                    end else ready[d] = ($urandom_range(99) < pct);
                    if (ready[d]) idx++;
                    else stalls++;
                end else begin
                    chk("last_idle", ol, 0);
                    gaps++;
                    start[d] = 1'b0;
                    ready[d] = ($urandom_range(99) < pct);
                end
                cyc();
            end
        end
        chk("finished", fin, 1);
        start[d] = 1'b0;
        ready[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            int s, k, sp;
            s = i / 8;
            k = i % 8;
            sp = 8 >> s;
            ma[i] = (k / sp) * 2 * sp + k % sp;
            mb[i] = ma[i] + sp;
            mt[i] = ((k % sp) << s) % 8;
        end
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            sample(d);
            chk("reset_state", {ov, ost, ok_, oa, ob, otw, ol, obusy, odone}, 0);
        end
        rst = 1'b0;
        cyc();
        run_tf(0, 2, 100, -1, -1);
        run_tf(0, 2, 60, 21, -1);
        run_tf(0, 2, 70, -1, 19);
        run_tf(0, 2, 100, -1, -1);
        run_tf(1, 0, 100, -1, -1);
        run_tf(1, 0, 50, 5, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
